// File: rtl/wb_memtest.sv
// Wishbone B3 classic memory-test initiator: writes pat(i) = i ^ seed over a word
// range, reads it back and compares. Optional ack watchdog under `WB_MEMTEST_TIMEOUT_EN.
module wb_memtest #(
    parameter int ADR_W   = 23,
    parameter int DAT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk2x_i,
    input  logic             reset_in,
    input  logic             start_i,
    input  logic [ADR_W-1:0] base_adr_i,
    input  logic [ADR_W-1:0] count_i,
    input  logic [DAT_W-1:0] seed_i,
    input  logic             ram_rst_i,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [1:0]       wb_sel_o,
    output logic [ADR_W-1:0] wb_adr_o,
    output logic [DAT_W-1:0] wb_dat_o,
    input  logic [DAT_W-1:0] wb_dat_i,
    input  logic             wb_ack_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             fail_o,
    output logic [ADR_W-1:0] err_adr_o,
    output logic [DAT_W-1:0] err_dat_o,
    output logic             timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAITRDY, S_WR, S_WGAP, S_RD, S_RGAP, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [ADR_W-1:0] idx_q, base_q, count_q;
    logic [DAT_W-1:0] seed_q;
    logic             fail_q, tmo_q;
    logic [ADR_W-1:0] err_adr_q;
    logic [DAT_W-1:0] err_dat_q;

    logic             take_start, idx_inc, idx_clr, set_err, set_tmo;
    logic             stb, last, tmo_hit;
    logic [ADR_W-1:0] cur_adr;
    logic [DAT_W-1:0] cur_pat;

    assign stb     = (state_q == S_WR) || (state_q == S_RD);
    assign cur_adr = base_q + idx_q;  // wraps modulo 2^ADR_W
    assign cur_pat = DAT_W'(idx_q) ^ seed_q;
    assign last    = (idx_q == count_q - ADR_W'(1));

`ifdef WB_MEMTEST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    assign tmo_hit = stb && !wb_ack_i && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk2x_i or negedge reset_in) begin
        if (!reset_in)              tmo_cnt_q <= '0;
        else if (stb && !wb_ack_i)  tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        else                        tmo_cnt_q <= '0;
    end
`else
    // never true: without the watchdog the block waits for ack indefinitely
    assign tmo_hit = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk2x_i or negedge reset_in) begin
        if (!reset_in) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        take_start = 1'b0;
        idx_inc    = 1'b0;
        idx_clr    = 1'b0;
        set_err    = 1'b0;
        set_tmo    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    take_start = 1'b1;
                    state_d    = (count_i == '0) ? S_DONE : S_WAITRDY;
                end
            end
            S_WAITRDY: begin
                if (!ram_rst_i) begin
                    idx_clr = 1'b1;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (tmo_hit) begin
                    set_tmo = 1'b1;
                    state_d = S_DONE;
                end else if (wb_ack_i) begin
                    state_d = S_WGAP;
                end
            end
            S_WGAP: begin
                if (last) begin
                    idx_clr = 1'b1;
                    state_d = S_RD;
                end else begin
                    idx_inc = 1'b1;
                    state_d = S_WR;
                end
            end
            S_RD: begin
                if (tmo_hit) begin
                    set_tmo = 1'b1;
                    state_d = S_DONE;
                end else if (wb_ack_i) begin
                    // abort on the first miscompare
                    if (wb_dat_i != cur_pat) begin
                        set_err = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RGAP;
                    end
                end
            end
            S_RGAP: begin
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    idx_inc = 1'b1;
                    state_d = S_RD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk2x_i or negedge reset_in) begin
        if (!reset_in) begin
            idx_q     <= '0;
            base_q    <= '0;
            count_q   <= '0;
            seed_q    <= '0;
            fail_q    <= 1'b0;
            tmo_q     <= 1'b0;
            err_adr_q <= '0;
            err_dat_q <= '0;
        end else begin
            if (take_start) begin
                base_q    <= base_adr_i;
                count_q   <= count_i;
                seed_q    <= seed_i;
                idx_q     <= '0;
                fail_q    <= 1'b0;
                tmo_q     <= 1'b0;
                err_adr_q <= '0;
                err_dat_q <= '0;
            end
            if (idx_clr)      idx_q <= '0;
            else if (idx_inc) idx_q <= idx_q + ADR_W'(1);
            if (set_err) begin
                fail_q    <= 1'b1;
                err_adr_q <= cur_adr;
                err_dat_q <= wb_dat_i;
            end
            if (set_tmo) begin
                fail_q    <= 1'b1;
                tmo_q     <= 1'b1;
                err_adr_q <= cur_adr;
                err_dat_q <= '0;
            end
        end
    end

    assign wb_cyc_o  = stb;
    assign wb_stb_o  = stb;
    assign wb_we_o   = (state_q == S_WR);
    assign wb_sel_o  = stb ? 2'b11 : 2'b00;
    assign wb_adr_o  = stb ? cur_adr : '0;
    assign wb_dat_o  = (state_q == S_WR) ? cur_pat : '0;
    assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o    = (state_q == S_DONE);
    assign fail_o    = fail_q;
    assign err_adr_o = err_adr_q;
    assign err_dat_o = err_dat_q;
    assign timeout_o = tmo_q;

endmodule

// File: tb/tb_wb_memtest.sv
// Directed bench for wb_memtest with a latency-configurable Wishbone slave and a
// 16-word RAM model indexed by the low address bits.
module tb_wb_memtest;

    logic        clk2x_i = 1'b0;
    logic        reset_in;
    logic        start_i;
    logic [22:0] base_adr_i, count_i;
    logic [15:0] seed_i;
    logic        ram_rst_i;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [1:0]  wb_sel_o;
    logic [22:0] wb_adr_o;
    logic [15:0] wb_dat_o, wb_dat_i;
    logic        wb_ack_i;
    logic        busy_o, done_o, fail_o, timeout_o;
    logic [22:0] err_adr_o;
    logic [15:0] err_dat_o;

    int tests_run = 0;
    int tests_failed = 0;

    wb_memtest #(.ADR_W(23), .DAT_W(16), .TIMEOUT(64)) dut (
        .clk2x_i(clk2x_i), .reset_in(reset_in), .start_i(start_i),
        .base_adr_i(base_adr_i), .count_i(count_i), .seed_i(seed_i),
        .ram_rst_i(ram_rst_i), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
        .err_adr_o(err_adr_o), .err_dat_o(err_dat_o), .timeout_o(timeout_o)
    );

    always #5 clk2x_i = ~clk2x_i;

    // slave model: ack after lat strobe cycles; ack_en=0 models a dead slave
    int          lat = 6;
    bit          ack_en = 1'b1;
    bit          corrupt = 1'b0;
    int          lat_cnt;
    logic [15:0] mem [0:15];
    logic [22:0] log_adr[$];
    logic [15:0] log_dat[$];
    logic        log_we[$];
    logic [1:0]  log_sel[$];

    assign wb_ack_i = ack_en && wb_stb_o && (lat_cnt == lat - 1);

    always_comb begin
        wb_dat_i = mem[wb_adr_o[3:0]];
        if (corrupt && wb_adr_o == 23'h012347) wb_dat_i = 16'h0000;
    end

    always @(posedge clk2x_i or negedge reset_in) begin
        if (!reset_in)                  lat_cnt <= 0;
        else if (wb_stb_o && !wb_ack_i) lat_cnt <= lat_cnt + 1;
        else                            lat_cnt <= 0;
    end

    always @(posedge clk2x_i) begin
        if (reset_in && wb_stb_o && wb_ack_i) begin
            log_adr.push_back(wb_adr_o);
            log_dat.push_back(wb_we_o ? wb_dat_o : wb_dat_i);
            log_we.push_back(wb_we_o);
            log_sel.push_back(wb_sel_o);
            if (wb_we_o) mem[wb_adr_o[3:0]] <= wb_dat_o;
        end
    end

    task automatic clear_log();
        log_adr.delete(); log_dat.delete(); log_we.delete(); log_sel.delete();
    endtask

    task automatic start_run(input logic [22:0] b, input logic [22:0] c, input logic [15:0] s);
        clear_log();
        @(negedge clk2x_i);
        base_adr_i = b; count_i = c; seed_i = s; start_i = 1'b1;
        @(negedge clk2x_i);
        start_i = 1'b0;
    endtask

    // cycles = negedges from first cyc up to (not including) done; first = negedge index of first cyc
    task automatic wait_done(output int cycles, output int first, output bit ok);
        bit started = 1'b0;
        cycles = 0; first = 0; ok = 1'b0;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk2x_i);
            if (done_o) begin ok = 1'b1; break; end
            if (wb_cyc_o && !started) begin started = 1'b1; first = n; end
            if (started) cycles++;
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b0; start_i = 1'b1; ram_rst_i = 1'b0;
        base_adr_i = 23'h1; count_i = 23'h4; seed_i = 16'h1;
        #12;
        tests_run++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o} !== '0) begin
            tests_failed++; $display("FAIL reset_bus: got cyc=%b adr=%h dat=%h want 0", wb_cyc_o, wb_adr_o, wb_dat_o);
        end
        #13;
        tests_run++;
        if ({busy_o, done_o, fail_o, err_adr_o, err_dat_o, timeout_o} !== '0) begin
            tests_failed++; $display("FAIL reset_status: got busy=%b done=%b fail=%b err_adr=%h want 0", busy_o, done_o, fail_o, err_adr_o);
        end
        #5;
        reset_in = 1'b1; start_i = 1'b0;
    endtask

    // boot gate followed by the full pass run
    task automatic test_boot_pass();
        int cyc_n, first;
        bit ok, saw_cyc;
        logic [15:0] exp_w [4] = '{16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6};
        lat = 6; ram_rst_i = 1'b1;
        start_run(23'h012345, 23'd4, 16'hA5A5);
        saw_cyc = 1'b0;
        tests_run++;
        if (busy_o !== 1'b1) begin
            tests_failed++; $display("FAIL boot_busy: got %b want 1", busy_o);
        end
        for (int k = 0; k < 4; k++) begin
            if (wb_cyc_o) saw_cyc = 1'b1;
            @(negedge clk2x_i);
        end
        tests_run++;
        if (saw_cyc !== 1'b0) begin
            tests_failed++; $display("FAIL boot_cyc: cyc seen while ram_rst_i=1");
        end
        ram_rst_i = 1'b0;
        wait_done(cyc_n, first, ok);
        tests_run++;
        if (!ok || first != 1) begin
            tests_failed++; $display("FAIL boot_first_wr: done=%b first cyc at %0d want 1", ok, first);
        end
        tests_run++;
        if (log_adr.size() != 8) begin
            tests_failed++; $display("FAIL pass_xfers: got %0d want 8", log_adr.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (log_adr[k] !== 23'h012345 + 23'(k % 4) || log_dat[k] !== exp_w[k % 4] ||
                    log_we[k] !== (k < 4) || log_sel[k] !== 2'b11) begin
                    tests_failed++;
                    $display("FAIL pass_xfer%0d: got adr=%h dat=%h we=%b sel=%b want adr=%h dat=%h we=%b sel=11",
                             k, log_adr[k], log_dat[k], log_we[k], log_sel[k], 23'h012345 + 23'(k % 4), exp_w[k % 4], k < 4);
                    break;
                end
            end
        end
        tests_run++;
        if (cyc_n != 56) begin
            tests_failed++; $display("FAIL pass_cycles: got %0d want 56", cyc_n);
        end
        tests_run++;
        if (done_o !== 1'b1 || fail_o !== 1'b0 || busy_o !== 1'b0) begin
            tests_failed++; $display("FAIL pass_status: got done=%b fail=%b busy=%b want 1 0 0", done_o, fail_o, busy_o);
        end
    endtask

    task automatic test_wrap();
        int cyc_n, first;
        bit ok, bad;
        logic [22:0] exp_a [3] = '{23'h7FFFFE, 23'h7FFFFF, 23'h000000};
        lat = 1;
        start_run(23'h7FFFFE, 23'd3, 16'h1234);
        wait_done(cyc_n, first, ok);
        bad = (log_adr.size() != 6);
        for (int k = 0; k < 6 && !bad; k++)
            if (log_adr[k] !== exp_a[k % 3]) bad = 1'b1;
        tests_run++;
        if (bad) begin
            tests_failed++; $display("FAIL wrap_adr: got %0d xfers first=%h want 6 at 7FFFFE,7FFFFF,000000",
                                     log_adr.size(), log_adr.size() ? log_adr[0] : 23'h0);
        end
        tests_run++;
        if (!ok || fail_o !== 1'b0 || cyc_n != 12) begin
            tests_failed++; $display("FAIL wrap_status: got done=%b fail=%b cycles=%0d want 1 0 12", ok, fail_o, cyc_n);
        end
    endtask

    task automatic test_fail();
        int cyc_n, first;
        bit ok, late_rd;
        lat = 6; corrupt = 1'b1;
        start_run(23'h012345, 23'd4, 16'hA5A5);
        wait_done(cyc_n, first, ok);
        corrupt = 1'b0;
        tests_run++;
        if (!ok || fail_o !== 1'b1 || err_adr_o !== 23'h012347 || err_dat_o !== 16'h0000) begin
            tests_failed++; $display("FAIL fail_err: got done=%b fail=%b err_adr=%h err_dat=%h want 1 1 012347 0000",
                                     ok, fail_o, err_adr_o, err_dat_o);
        end
        late_rd = 1'b0;
        for (int k = 0; k < log_adr.size(); k++)
            if (!log_we[k] && log_adr[k] == 23'h012348) late_rd = 1'b1;
        tests_run++;
        if (late_rd || log_adr.size() != 7) begin
            tests_failed++; $display("FAIL fail_abort: got %0d xfers read_012348=%b want 7 0", log_adr.size(), late_rd);
        end
        tests_run++;
        if (timeout_o !== 1'b0) begin
            tests_failed++; $display("FAIL fail_timeout_flag: got %b want 0", timeout_o);
        end
    endtask

    task automatic test_count_zero();
        start_run(23'h000040, 23'd0, 16'hFFFF);
        tests_run++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || fail_o !== 1'b0 || err_adr_o !== 23'h0) begin
            tests_failed++; $display("FAIL zero_status: got done=%b busy=%b fail=%b err_adr=%h want 1 0 0 0",
                                     done_o, busy_o, fail_o, err_adr_o);
        end
        repeat (3) @(negedge clk2x_i);
        tests_run++;
        if (log_adr.size() != 0 || wb_cyc_o !== 1'b0) begin
            tests_failed++; $display("FAIL zero_bus: got %0d xfers cyc=%b want 0 0", log_adr.size(), wb_cyc_o);
        end
    endtask

    task automatic test_busy_ignore();
        int cyc_n, first;
        bit ok;
        lat = 2;
        start_run(23'h000100, 23'd2, 16'h0F0F);
        repeat (3) @(negedge clk2x_i);
        base_adr_i = 23'h000200; count_i = 23'd1; start_i = 1'b1; ram_rst_i = 1'b1;
        @(negedge clk2x_i);
        start_i = 1'b0;
        wait_done(cyc_n, first, ok);
        ram_rst_i = 1'b0;
        tests_run++;
        if (!ok || fail_o !== 1'b0 || log_adr.size() != 4 || log_adr[0] !== 23'h000100 || log_adr[3] !== 23'h000101) begin
            tests_failed++; $display("FAIL busy_ignore: got done=%b fail=%b xfers=%0d want 1 0 4 at 100..101",
                                     ok, fail_o, log_adr.size());
        end
    endtask

    task automatic test_mid_reset();
        lat = 6;
        start_run(23'h012345, 23'd4, 16'hA5A5);
        repeat (4) @(negedge clk2x_i);
        tests_run++;
        if (wb_cyc_o !== 1'b1) begin
            tests_failed++; $display("FAIL midrst_pre: cyc got %b want 1", wb_cyc_o);
        end
        #2 reset_in = 1'b0;
        #1;
        tests_run++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, busy_o, done_o} !== '0) begin
            tests_failed++; $display("FAIL midrst_async: got cyc=%b busy=%b adr=%h want 0", wb_cyc_o, busy_o, wb_adr_o);
        end
        @(negedge clk2x_i);
        reset_in = 1'b1;
    endtask

`ifdef WB_MEMTEST_TIMEOUT_EN
    task automatic test_timeout();
        int hi;
        bit seen;
        ack_en = 1'b0;
        start_run(23'h000050, 23'd2, 16'h0000);
        seen = 1'b0; hi = 0;
        for (int n = 0; n < 300; n++) begin
            if (wb_cyc_o) begin seen = 1'b1; hi++; end
            else if (seen) break;
            @(negedge clk2x_i);
        end
        ack_en = 1'b1;
        tests_run++;
        if (hi != 64) begin
            tests_failed++; $display("FAIL timeout_cycles: got %0d want 64", hi);
        end
        tests_run++;
        if (timeout_o !== 1'b1 || fail_o !== 1'b1 || done_o !== 1'b1 || err_adr_o !== 23'h000050 || err_dat_o !== 16'h0) begin
            tests_failed++; $display("FAIL timeout_status: got tmo=%b fail=%b done=%b err_adr=%h want 1 1 1 000050",
                                     timeout_o, fail_o, done_o, err_adr_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_boot_pass();
        test_wrap();
        test_fail();
        test_count_zero();
        test_busy_ignore();
        test_mid_reset();
`ifdef WB_MEMTEST_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
